// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low (common anode).
package seven_seg_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {OFF, GUARD, DRIVE} scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input nibble_t value);
    logic [6:0] pattern;
    case (value)
      4'h0: pattern = 7'b1000000;
      4'h1: pattern = 7'b1111001;
      4'h2: pattern = 7'b0100100;
      4'h3: pattern = 7'b0110000;
      4'h4: pattern = 7'b0011001;
      4'h5: pattern = 7'b0010010;
      4'h6: pattern = 7'b0000010;
      4'h7: pattern = 7'b1111000;
      4'h8: pattern = 7'b0000000;
      4'h9: pattern = 7'b0010000;
      4'hA: pattern = 7'b0001000;
      4'hB: pattern = 7'b0000011;
      4'hC: pattern = 7'b1000110;
      4'hD: pattern = 7'b0100001;
      4'hE: pattern = 7'b0000110;
      default: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seven_segment_display.sv
// Combinational hex-nibble to active-low segment decoder.
module seven_segment_display
  import seven_seg_pkg::*;
(
  input  nibble_t    value,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(value);

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one decoder, with dead-time between
// slots and a double-buffered load port that only swaps values at frame boundaries.
module seven_segment_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    lz_suppress,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  // Every slot opens with dead-time unless the guard is configured away.
  localparam scan_state_t SLOT_START = (GUARD_CYCLES == 0) ? DRIVE : GUARD;

  scan_state_t             state_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [4*NUM_DIGITS-1:0] active_value_reg;
  logic [NUM_DIGITS-1:0]   active_dp_reg;
  logic [4*NUM_DIGITS-1:0] pend_value_reg;
  logic [NUM_DIGITS-1:0]   pend_dp_reg;
  logic                    pend_valid_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic [6:0]              seg_reg;
  logic                    dp_reg;

  nibble_t               nib [NUM_DIGITS];
  logic [NUM_DIGITS:0]   upper_zero;
  nibble_t               cur_nib;
  logic [6:0]            dec_seg;
  logic                  blank;
  logic                  boundary;

  // upper_zero[i] is set when nibbles NUM_DIGITS-1 down to i of the active value are all zero.
  assign upper_zero[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi]        = active_value_reg[gi*4 +: 4];
    assign upper_zero[gi] = upper_zero[gi+1] && (nib[gi] == 4'h0);
  end

  assign cur_nib  = nib[idx_reg];
  assign blank    = lz_suppress && (idx_reg != '0) && upper_zero[idx_reg];
  assign boundary = (state_reg == DRIVE) && (cnt_reg == DRIVE_LAST) && (idx_reg == IDX_LAST);

  seven_segment_display u_decode (
    .value (cur_nib),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= OFF;
      idx_reg          <= '0;
      cnt_reg          <= '0;
      active_value_reg <= '0;
      active_dp_reg    <= '0;
      pend_value_reg   <= '0;
      pend_dp_reg      <= '0;
      pend_valid_reg   <= 1'b0;
      an_reg           <= '1;
      seg_reg          <= SEG_BLANK;
      dp_reg           <= 1'b1;
    end else begin
      if (state_reg == DRIVE) begin
        an_reg  <= ~(NUM_DIGITS'(1) << idx_reg);
        seg_reg <= blank ? SEG_BLANK : dec_seg;
        dp_reg  <= ~active_dp_reg[idx_reg];
      end else begin
        an_reg  <= '1;
        seg_reg <= SEG_BLANK;
        dp_reg  <= 1'b1;
      end

      if (!enable) begin
        state_reg <= OFF;
        idx_reg   <= '0;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          OFF: begin
            state_reg <= SLOT_START;
            idx_reg   <= '0;
            cnt_reg   <= '0;
          end
          GUARD: begin
            if (cnt_reg == GUARD_LAST) begin
              state_reg <= DRIVE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          DRIVE: begin
            if (cnt_reg == DRIVE_LAST) begin
              cnt_reg   <= '0;
              idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
              state_reg <= SLOT_START;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: state_reg <= OFF;
        endcase
      end

      // A load can only be accepted with pending empty and only a full pending transfers,
      // so a load landing on a boundary waits for the next one.
      if (pend_valid_reg && (boundary || state_reg == OFF)) begin
        active_value_reg <= pend_value_reg;
        active_dp_reg    <= pend_dp_reg;
        pend_valid_reg   <= 1'b0;
      end else if (load_valid && !pend_valid_reg) begin
        pend_value_reg <= load_value;
        pend_dp_reg    <= load_dp;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  assign load_ready = !pend_valid_reg;
  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Cycle-by-cycle check of the scan controller against a frame-position model
// (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, so a 20-cycle frame of 5-cycle slots).
module tb_seven_segment_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 1;
  localparam int SLOT  = R + G;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          lz_suppress = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [4*N-1:0] load_value = '0;
  logic [N-1:0]  load_dp = '0;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: position within the frame when scanning, plus the two buffers.
  bit             m_off = 1'b1;
  int             m_pos = 0;
  logic [4*N-1:0] m_act = '0;
  logic [N-1:0]   m_act_dp = '0;
  logic [4*N-1:0] m_pend_v = '0;
  logic [N-1:0]   m_pend_dp = '0;
  bit             m_pend = 1'b0;

  seven_segment_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .lz_suppress (lz_suppress),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .load_dp     (load_dp),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  task automatic step();
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_dp;
    logic         e_ready;
    int           slot;
    logic [4*N-1:0] upper;
    bit           bnd;
    e_an  = '1;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    slot  = m_pos / SLOT;
    if (!m_off && (m_pos % SLOT) != 0) begin
      upper = m_act >> (4 * slot);
      e_an  = ~(N'(1) << slot);
      e_seg = (lz_suppress && slot > 0 && upper == 0) ? 7'h7F : seg_tbl[upper[3:0]];
      e_dp  = ~m_act_dp[slot];
    end
    bnd = !m_off && (m_pos == FRAME - 1);
    if (rst) begin
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
      m_off = 1'b1; m_pos = 0; m_act = '0; m_act_dp = '0; m_pend = 1'b0;
    end else begin
      if (m_pend && (m_off || bnd)) begin
        m_act = m_pend_v; m_act_dp = m_pend_dp; m_pend = 1'b0;
      end else if (load_valid && !m_pend) begin
        m_pend_v = load_value; m_pend_dp = load_dp; m_pend = 1'b1;
      end
      if (!enable) m_off = 1'b1;
      else if (m_off) begin m_off = 1'b0; m_pos = 0; end
      else m_pos = (m_pos + 1) % FRAME;
    end
    e_ready = !m_pend;
    @(posedge clk);
    #1;
    tests++;
    assert (an === e_an) else begin fails++; $error("FAIL an: got %b expected %b at %0t", an, e_an, $time); end
    tests++;
    assert (seg === e_seg) else begin fails++; $error("FAIL seg: got %b expected %b at %0t", seg, e_seg, $time); end
    tests++;
    assert (dp === e_dp) else begin fails++; $error("FAIL dp: got %b expected %b at %0t", dp, e_dp, $time); end
    tests++;
    assert (load_ready === e_ready) else begin fails++; $error("FAIL load_ready: got %b expected %b at %0t", load_ready, e_ready, $time); end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [4*N-1:0] v, input logic [N-1:0] d);
    load_value = v; load_dp = d; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  // Advance until the model's next cycle sits at frame position pos while scanning.
  task automatic wait_pos(input int pos, input bit need_empty, input string tag);
    int  k = 0;
    bit  found = 1'b0;
    while (k < 200 && !found) begin
      if (!m_off && m_pos == pos && (!need_empty || !m_pend)) found = 1'b1;
      else begin step(); k++; end
    end
    tests++;
    assert (found) else begin fails++; $error("FAIL %s: position %0d not reached within 200 cycles", tag, pos); end
  endtask

  initial begin
    // Reset state.
    run(3);
    rst = 1'b0;
    run(2);

    // Value loaded while dark, then scan 1234 for a bit over two frames.
    load(16'h1234, 4'b0000);
    run(2);
    enable = 1'b1;
    run(45);

    // Leading-zero suppression, including an all-zero value with a dp lit on a blanked digit.
    lz_suppress = 1'b1;
    load(16'h0050, 4'b0100);
    run(45);
    load(16'h0000, 4'b1001);
    run(45);
    lz_suppress = 1'b0;

    // Mid-frame load while 1234 is showing.
    load(16'h1234, 4'b0000);
    wait_pos(7, 1'b1, "midframe_wait");
    load(16'hABCD, 4'b0010);
    run(45);

    // Load accepted exactly on the boundary cycle.
    wait_pos(FRAME - 1, 1'b1, "boundary_wait");
    load(16'h5A6F, 4'b1000);
    run(45);

    // Enable dropped during DRIVE of digit 2, then restored.
    wait_pos(2 * SLOT + 2, 1'b0, "digit2_wait");
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(25);

    // Randomized loads, suppression and enable gaps.
    for (int r = 0; r < 12; r++) begin
      load_value  = $urandom() >> (4 * $urandom_range(0, N));
      load_dp     = N'($urandom());
      lz_suppress = $urandom_range(0, 1);
      load_valid  = 1'b1;
      run($urandom_range(1, 3));
      load_valid  = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 4));
        enable = 1'b1;
      end
      run($urandom_range(5, 40));
    end

    // Reset mid-DRIVE with a pending value that must never appear.
    lz_suppress = 1'b0;
    wait_pos(SLOT + 2, 1'b1, "rst_wait");
    load(16'hEEEE, 4'b1111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(45);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_ctrl.md
Name: seven_segment_scan_ctrl

Overview:
Time-multiplexes one common-anode 7-segment decoder across NUM_DIGITS digits of a multi-digit display. It drives one active-low anode at a time, with a dead-time guard between digits to stop ghosting. Display values arrive through a valid/ready load port and are double-buffered, so a new value only takes effect at a frame boundary and frames never tear. It sits between the debug/register-view logic (for example, PC and register readout) and the board display pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits; digit 0 is least significant (rightmost); must be >= 2.
REFRESH_DIV, 50000, clk cycles an anode stays driven per digit slot; must be >= 2.
GUARD_CYCLES, 2, cycles with all anodes off between slots; 0 removes the GUARD state.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  1 = scan; 0 = display dark
lz_suppress  in  1  1 = blank leading zero digits
load_valid  in  1  load request
load_ready  out  1  load can be accepted
load_value  in  4*NUM_DIGITS  hex nibbles; nibble i is digit i
load_dp  in  NUM_DIGITS  decimal-point enables; 1 = lit
an  out  NUM_DIGITS  anode selects, active-low
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low

Behaviour:
- Reset values: state OFF, idx 0, slot counter 0, active value and dp all 0, pending empty, load_ready 1, an all 1s, seg 7'h7F, dp 1.
- State machine: OFF, GUARD, DRIVE.
  - OFF -> GUARD, with idx 0, when enable is 1. If GUARD_CYCLES = 0, go straight to DRIVE.
  - GUARD holds for GUARD_CYCLES cycles, with all anodes off, then -> DRIVE.
  - DRIVE holds for REFRESH_DIV cycles with an[idx] = 0.
  - At the end of DRIVE: idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1, then -> GUARD (or DRIVE if GUARD_CYCLES = 0).
- Frame boundary: the last DRIVE cycle with idx == NUM_DIGITS-1.
- enable = 0 in any state: next cycle go to OFF and reset the counters. an, seg and dp are all 1s one cycle later.
- Output timing: an, seg and dp are registered, so they reflect the state and idx of the previous cycle (1-cycle latency). Outside DRIVE: an all 1s, seg 7'h7F, dp 1.
- Segment decode uses the team's standard hex patterns: 0 = 7'b1000000 through F = 7'b0001110. A blanked digit gives seg 7'h7F and dp 1.
- Leading-zero suppression, when lz_suppress = 1: digit i (i >= 1) is blanked if nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never suppressed, so value 0 shows a single "0". Suppression is evaluated on the active buffer. dp is independent of suppression: a lit dp on a suppressed digit still drives dp = 0 with seg 7'h7F.
- Load handshake:
  - A load is accepted when load_valid & load_ready; the data goes into the pending buffer and pending_valid is set.
  - load_ready = !pending_valid (registered).
  - Pending is copied to the active buffer on a frame boundary cycle, or on any cycle while in OFF.
  - pending_valid clears in that cycle, so load_ready rises the next cycle.
- Same-cycle accept and boundary: only a pending_valid that was already set transfers. A load accepted in the boundary cycle (only possible with pending empty) waits for the next boundary.
- Reset mid-frame: everything returns to reset values and pending data is discarded.

Decomposition:
- Package seven_seg_pkg:
  - nibble_t (logic [3:0])
  - scan_state_t enum {OFF, GUARD, DRIVE}
  - SEG_BLANK = 7'h7F
  - hex-to-segment constant function
- One sub-module: the existing seven_segment_display decoder, fed by the idx-selected active nibble. This controller applies blanking and registers the outputs.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1):
1. Reset, enable=1, value 16'h1234 loaded while OFF -> repeating pattern: 1 guard cycle, then 4 cycles an=4'b1110 / seg=7'b0110000 ("4"), then an=1101 "3", 1011 "2", 0111 "1". Frame period is 20 cycles.
2. lz_suppress=1, value 16'h0050 -> digits 3 and 2 give seg 7'h7F, digit 1 "5", digit 0 "0". Value 16'h0000 -> only digit 0 shows "0".
3. Load 16'hABCD mid-frame while showing 16'h1234 -> load_ready drops the next cycle. The remaining slots of that frame still show 1234; the next frame shows D,C,B,A. load_ready returns 1 the cycle after the boundary.
4. Load accepted exactly on a boundary cycle -> the value does not display until the following frame, exactly 20 cycles later.
5. Deassert enable during DRIVE of digit 2 -> an=4'hF and seg=7'h7F within 2 cycles. Re-enable -> scan restarts at digit 0 after 1 guard cycle.
6. Assert rst mid-DRIVE with pending_valid=1 -> next cycle all outputs are at reset values, load_ready=1, and the pending value is never displayed.
